// File: rtl/ahb_slave_port_mux.sv
// Per-slave AHB port mux: routes the granted master's address phase to the
// slave and returns the data-phase response to the master that owns it.
module ahb_slave_port_mux #(
    parameter int MASTER_NUM  = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                         hclk,
    input  logic                         hreset_n,
    input  logic [MASTER_NUM-1:0]        hgrant,
    input  logic [MASTER_NUM*ADDR_W-1:0] m_haddr,
    input  logic [MASTER_NUM*2-1:0]      m_htrans,
    input  logic [MASTER_NUM-1:0]        m_hwrite,
    input  logic [MASTER_NUM*3-1:0]      m_hsize,
    input  logic [MASTER_NUM*3-1:0]      m_hburst,
    input  logic [MASTER_NUM*DATA_W-1:0] m_hwdata,
    input  logic                         s_hreadyout,
    input  logic                         s_hresp,
    input  logic [DATA_W-1:0]            s_hrdata,
    output logic                         s_hsel,
    output logic [ADDR_W-1:0]            s_haddr,
    output logic [1:0]                   s_htrans,
    output logic                         s_hwrite,
    output logic [2:0]                   s_hsize,
    output logic [2:0]                   s_hburst,
    output logic [DATA_W-1:0]            s_hwdata,
    output logic                         s_hready,
    output logic [MASTER_NUM-1:0]        m_hready,
    output logic [MASTER_NUM-1:0]        m_hresp,
    output logic [DATA_W-1:0]            m_hrdata,
    output logic                         hwait,
    output logic                         err_onehot,
    output logic                         err_timeout
);

    typedef enum logic [1:0] {
        D_IDLE   = 2'd0,
        D_ACTIVE = 2'd1,
        D_ERR    = 2'd2
    } dstate_e;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

    dstate_e               state_q, state_d;
    logic [MASTER_NUM-1:0] owner_q, owner_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  err_onehot_q, err_onehot_d;
    logic                  err_timeout_q, err_timeout_d;

    logic [MASTER_NUM-1:0] gnt_oh;
    logic                  multi_hot;
    logic                  xfer_req;

    // Isolate the lowest set grant bit so a multi-hot grant still routes one master
    assign gnt_oh    = hgrant & (~hgrant + MASTER_NUM'(1));
    assign multi_hot = |(hgrant & (hgrant - MASTER_NUM'(1)));

    always_comb begin
        s_hsel   = 1'b0;
        s_haddr  = '0;
        s_htrans = 2'b00;
        s_hwrite = 1'b0;
        s_hsize  = 3'b000;
        s_hburst = 3'b000;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (gnt_oh[i]) begin
                s_hsel   = 1'b1;
                s_haddr  = m_haddr[i*ADDR_W +: ADDR_W];
                s_htrans = m_htrans[i*2 +: 2];
                s_hwrite = m_hwrite[i];
                s_hsize  = m_hsize[i*3 +: 3];
                s_hburst = m_hburst[i*3 +: 3];
            end
        end
    end

    assign xfer_req = s_hsel & s_htrans[1];

    always_comb begin
        s_hwdata = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (owner_q[i]) begin
                s_hwdata = m_hwdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign s_hready = (state_q == D_IDLE) ? 1'b1 : s_hreadyout;
    assign hwait    = ~s_hready;
    assign m_hrdata = s_hrdata;

    always_comb begin
        m_hready = '1;
        m_hresp  = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            if (owner_q[i]) begin
                m_hready[i] = s_hready;
                m_hresp[i]  = s_hresp;
            end
        end
    end

    always_comb begin
        owner_d = owner_q;
        if (s_hready) begin
            owner_d = xfer_req ? gnt_oh : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            D_IDLE: begin
                if (|owner_d) state_d = D_ACTIVE;
            end
            D_ACTIVE: begin
                if (!s_hreadyout && s_hresp) begin
                    state_d = D_ERR;
                end else if (s_hreadyout && !(|owner_d)) begin
                    state_d = D_IDLE;
                end
            end
            D_ERR: begin
                // A low hresp here is a slave bug; it still closes the transfer
                if (s_hreadyout) begin
                    state_d = (|owner_d) ? D_ACTIVE : D_IDLE;
                end
            end
            default: state_d = D_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (s_hreadyout) begin
            cnt_d = '0;
        end else if (state_q != D_IDLE && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_comb begin
        err_onehot_d  = err_onehot_q | multi_hot;
        err_timeout_d = err_timeout_q;
        if (TIMEOUT_CYC != 0 && cnt_d == TO_LIM) begin
            err_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q       <= D_IDLE;
            owner_q       <= '0;
            cnt_q         <= '0;
            err_onehot_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            err_onehot_q  <= err_onehot_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_onehot  = err_onehot_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_ahb_slave_port_mux.sv
// Directed bench for ahb_slave_port_mux; write data is checked through
// a scoreboard queue filled when the address phase is driven.
module tb_ahb_slave_port_mux;

    localparam int MN = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              hclk;
    logic              hreset_n;
    logic [MN-1:0]     hgrant;
    logic [MN*AW-1:0]  m_haddr;
    logic [MN*2-1:0]   m_htrans;
    logic [MN-1:0]     m_hwrite;
    logic [MN*3-1:0]   m_hsize;
    logic [MN*3-1:0]   m_hburst;
    logic [MN*DW-1:0]  m_hwdata;
    logic              s_hreadyout;
    logic              s_hresp;
    logic [DW-1:0]     s_hrdata;
    logic              s_hsel;
    logic [AW-1:0]     s_haddr;
    logic [1:0]        s_htrans;
    logic              s_hwrite;
    logic [2:0]        s_hsize;
    logic [2:0]        s_hburst;
    logic [DW-1:0]     s_hwdata;
    logic              s_hready;
    logic [MN-1:0]     m_hready;
    logic [MN-1:0]     m_hresp;
    logic [DW-1:0]     m_hrdata;
    logic              hwait;
    logic              err_onehot;
    logic              err_timeout;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] wq[$];

    ahb_slave_port_mux #(
        .MASTER_NUM(MN), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(4)
    ) dut (
        .hclk(hclk), .hreset_n(hreset_n), .hgrant(hgrant),
        .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite),
        .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hwdata(m_hwdata),
        .s_hreadyout(s_hreadyout), .s_hresp(s_hresp), .s_hrdata(s_hrdata),
        .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans),
        .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
        .s_hwdata(s_hwdata), .s_hready(s_hready), .m_hready(m_hready),
        .m_hresp(m_hresp), .m_hrdata(m_hrdata), .hwait(hwait),
        .err_onehot(err_onehot), .err_timeout(err_timeout)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wdata(input string tag);
        logic [31:0] e;
        if (wq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s observed=%0h expected=<empty queue>", tag, s_hwdata);
        end else begin
            e = wq.pop_front();
            chk(tag, 64'(s_hwdata), 64'(e));
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input int i, input logic [31:0] a,
                         input logic [1:0] t, input logic w,
                         input logic [31:0] d);
        m_haddr[i*AW +: AW] = a;
        m_htrans[i*2 +: 2]  = t;
        m_hwrite[i]         = w;
        m_hsize[i*3 +: 3]   = 3'd2;
        m_hburst[i*3 +: 3]  = 3'd0;
        m_hwdata[i*DW +: DW] = d;
    endtask

    initial begin
        hreset_n    = 1'b0;
        hgrant      = '0;
        m_haddr     = '0;
        m_htrans    = '0;
        m_hwrite    = '0;
        m_hsize     = '0;
        m_hburst    = '0;
        m_hwdata    = '0;
        s_hreadyout = 1'b1;
        s_hresp     = 1'b0;
        s_hrdata    = '0;
        #1;
        chk("rst_s_hready", 64'(s_hready), 64'd1);
        chk("rst_m_hready", 64'(m_hready), 64'd3);
        chk("rst_hwait", 64'(hwait), 64'd0);
        chk("rst_s_hsel", 64'(s_hsel), 64'd0);
        chk("rst_s_hwdata", 64'(s_hwdata), 64'd0);
        chk("rst_flags", 64'({err_onehot, err_timeout}), 64'd0);
        tick();
        tick();
        hreset_n = 1'b1;
        tick();

        // single write from master 0
        drive(0, 32'h1000, 2'd2, 1'b1, 32'hA0A0_A0A0);
        drive(1, 32'h0, 2'd0, 1'b0, 32'hB1B1_B1B1);
        hgrant = 2'b01;
        wq.push_back(32'hA0A0_A0A0);
        #1;
        chk("sw_s_haddr", 64'(s_haddr), 64'h1000);
        chk("sw_s_hsel", 64'(s_hsel), 64'd1);
        chk("sw_s_htrans", 64'(s_htrans), 64'd2);
        chk("sw_s_hwrite", 64'(s_hwrite), 64'd1);
        tick();
        hgrant = 2'b00;
        drive(0, 32'h0, 2'd0, 1'b0, 32'hA0A0_A0A0);
        #1;
        chk_wdata("sw_s_hwdata");
        chk("sw_m_hready", 64'(m_hready), 64'd3);
        chk("sw_idle_hsel", 64'(s_hsel), 64'd0);
        tick();
        chk("sw_after_wdata", 64'(s_hwdata), 64'd0);

        // back-to-back masters
        drive(0, 32'h1100, 2'd2, 1'b1, 32'h0000_0011);
        hgrant = 2'b01;
        wq.push_back(32'h0000_0011);
        tick();
        drive(0, 32'h0, 2'd0, 1'b0, 32'h0000_0011);
        drive(1, 32'h2200, 2'd2, 1'b1, 32'h0000_0022);
        hgrant = 2'b10;
        wq.push_back(32'h0000_0022);
        #1;
        chk_wdata("b2b_wdata0");
        chk("b2b_s_haddr1", 64'(s_haddr), 64'h2200);
        tick();
        hgrant = 2'b00;
        drive(1, 32'h0, 2'd0, 1'b0, 32'h0000_0022);
        #1;
        chk_wdata("b2b_wdata1");
        tick();

        // wait states on master 1
        drive(1, 32'h3300, 2'd2, 1'b1, 32'h0000_0033);
        hgrant = 2'b10;
        tick();
        hgrant = 2'b00;
        drive(1, 32'h0, 2'd0, 1'b0, 32'h0000_0033);
        s_hreadyout = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wq.push_back(32'h0000_0033);
            #1;
            chk("ws_hwait", 64'(hwait), 64'd1);
            chk("ws_m_hready", 64'(m_hready), 64'b01);
            chk_wdata("ws_wdata_held");
            tick();
        end
        s_hreadyout = 1'b1;
        #1;
        chk("ws_release_hwait", 64'(hwait), 64'd0);
        chk("ws_release_m_hready", 64'(m_hready), 64'd3);
        tick();
        chk("ws_no_timeout", 64'(err_timeout), 64'd0);

        // two-cycle error response, read from master 0
        drive(0, 32'h4400, 2'd2, 1'b0, 32'h0);
        hgrant = 2'b01;
        tick();
        hgrant = 2'b00;
        drive(0, 32'h0, 2'd0, 1'b0, 32'h0);
        s_hreadyout = 1'b0;
        s_hresp = 1'b1;
        s_hrdata = 32'hDEAD_BEEF;
        #1;
        chk("err1_m_hresp", 64'(m_hresp), 64'b01);
        chk("err1_m_hready", 64'(m_hready), 64'b10);
        chk("err_m_hrdata", 64'(m_hrdata), 64'hDEAD_BEEF);
        tick();
        s_hreadyout = 1'b1;
        #1;
        chk("err2_m_hresp", 64'(m_hresp), 64'b01);
        chk("err2_m_hready", 64'(m_hready), 64'd3);
        tick();
        s_hresp = 1'b0;
        s_hreadyout = 1'b0;
        #1;
        chk("err_back_idle_hready", 64'(s_hready), 64'd1);
        chk("err_back_idle_hresp", 64'(m_hresp), 64'd0);
        s_hreadyout = 1'b1;
        tick();

        // timeout after 4 stall cycles
        drive(1, 32'h5500, 2'd2, 1'b1, 32'h0000_0055);
        hgrant = 2'b10;
        tick();
        hgrant = 2'b00;
        drive(1, 32'h0, 2'd0, 1'b0, 32'h0000_0055);
        s_hreadyout = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("to_stall%0d", k), 64'(err_timeout),
                64'((k >= 4) ? 1 : 0));
        end
        s_hreadyout = 1'b1;
        tick();
        tick();
        chk("to_sticky", 64'(err_timeout), 64'd1);
        chk("to_idle_hready", 64'(s_hready), 64'd1);

        // multi-hot grant
        drive(0, 32'h2000, 2'd2, 1'b1, 32'h0000_0066);
        drive(1, 32'h3000, 2'd2, 1'b1, 32'h0000_0077);
        hgrant = 2'b11;
        wq.push_back(32'h0000_0066);
        #1;
        chk("mh_s_haddr", 64'(s_haddr), 64'h2000);
        chk("mh_flag_before", 64'(err_onehot), 64'd0);
        tick();
        hgrant = 2'b00;
        drive(0, 32'h0, 2'd0, 1'b0, 32'h0000_0066);
        drive(1, 32'h0, 2'd0, 1'b0, 32'h0000_0077);
        #1;
        chk("mh_flag", 64'(err_onehot), 64'd1);
        chk_wdata("mh_wdata_m0");
        tick();
        chk("mh_flag_sticky", 64'(err_onehot), 64'd1);

        // asynchronous reset during a stall
        drive(0, 32'h6000, 2'd2, 1'b1, 32'h0000_0088);
        hgrant = 2'b01;
        tick();
        hgrant = 2'b00;
        s_hreadyout = 1'b0;
        tick();
        chk("rs_stalled", 64'(s_hready), 64'd0);
        #1;
        hreset_n = 1'b0;
        #1;
        chk("rs_s_hready", 64'(s_hready), 64'd1);
        chk("rs_s_hwdata", 64'(s_hwdata), 64'd0);
        chk("rs_m_hready", 64'(m_hready), 64'd3);
        chk("rs_hwait", 64'(hwait), 64'd0);
        chk("rs_flags", 64'({err_onehot, err_timeout}), 64'd0);
        s_hreadyout = 1'b1;
        tick();
        hreset_n = 1'b1;
        tick();
        chk("rs_wq_drained", 64'(wq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
